// File: rtl/deser400_gate_pkg.sv
// deser400_gate_pkg: shared encodings for the programmable deser400 gate generator.
//   MODE_*        : cfg_mode encodings (2'b11 behaves as off)
//   state_t       : gate FSM states
//   CNT_W_DEFAULT : default period/length counter width
package deser400_gate_pkg;

    localparam int unsigned CNT_W_DEFAULT = 22;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_CONT   = 2'b01;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    // True for the two modes that keep the generator alive; anything else aborts.
    function automatic logic mode_active(input logic [1:0] mode);
        return (mode == MODE_CONT) || (mode == MODE_SINGLE);
    endfunction

endpackage

// File: rtl/deser400_gate_tc.sv
// deser400_gate_tc: period counter with shadowed period/length and terminal-count compare.
//   clk, reset_n   : clock, async active-low reset
//   load           : restart at 0 and capture cfg_period/cfg_length into the shadows
//   run            : count up by one (ignored when load is set); neither -> cnt cleared
//   cfg_period     : terminal count (period - 1)
//   cfg_length     : gate length in cycles
//   cnt            : current count
//   len_shadow     : gate length frozen for the current period
//   tc_c           : cnt equals the shadowed terminal count (combinational)
module deser400_gate_tc
    import deser400_gate_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             run,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_length,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] len_shadow,
    output logic             tc_c
);

    logic [CNT_W-1:0] per_shadow;

    // Counter and shadow registers; shadows only move on load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= '0;
            per_shadow <= '0;
            len_shadow <= '0;
        end else if (load) begin
            cnt        <= '0;
            per_shadow <= cfg_period;
            len_shadow <= cfg_length;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    assign tc_c = (cnt == per_shadow);

endmodule

// File: rtl/deser400_gate_gen.sv
// deser400_gate_gen: programmable periodic gate generator (continuous / single-shot).
//   clk, reset_n : 40 MHz clock, async active-low reset
//   cfg_period   : terminal count, period = cfg_period + 1 cycles
//   cfg_length   : gate high time in cycles (0 = never opens)
//   cfg_mode     : 00 off, 01 continuous, 10 single-shot, 11 off
//   trig         : single-shot start request
//   gate         : gate output
//   gate_start   : pulse in first cycle of each gate window
//   period_end   : pulse in last cycle of each period
//   busy         : period in progress
//   phase        : position within the period, aligned with gate
//   gate_count   : gate_start count, only when DESER400_GATE_CNT_EN is defined
// PIPE (0/1) adds one output register stage on all outputs.
module deser400_gate_gen
    import deser400_gate_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned PIPE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_length,
    input  logic [1:0]       cfg_mode,
    input  logic             trig,
    output logic             gate,
    output logic             gate_start,
    output logic             period_end,
    output logic             busy,
    output logic [CNT_W-1:0] phase
`ifdef DESER400_GATE_CNT_EN
    ,
    output logic [15:0]      gate_count
`endif
);

    state_t           state;
    logic             mode_ok_c;
    logic             active_c;
    logic             run_next_c;
    logic             load_c;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] len_shadow;
    logic             tc_c;

    logic             gate_s;
    logic             start_s;
    logic             end_s;
    logic             busy_s;
    logic [CNT_W-1:0] phase_s;

    assign mode_ok_c = mode_active(cfg_mode);
    // Qualifying with mode_ok_c makes an abort drop the outputs with the state change.
    assign active_c  = (state == RUN) && mode_ok_c;

    // Whether the next cycle is a RUN cycle.
    always_comb begin
        run_next_c = 1'b0;
        if (mode_ok_c) begin
            unique case (state)
                IDLE:    run_next_c = (cfg_mode == MODE_CONT);
                ARMED:   run_next_c = trig || (cfg_mode == MODE_CONT);
                RUN:     run_next_c = !(tc_c && (cfg_mode == MODE_SINGLE));
                default: run_next_c = 1'b0;
            endcase
        end
    end

    // Shadows are captured on entry to RUN and at each wrap that stays in RUN.
    assign load_c = run_next_c && ((state != RUN) || tc_c);

    deser400_gate_tc #(
        .CNT_W (CNT_W)
    ) u_tc (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (load_c),
        .run        (run_next_c),
        .cfg_period (cfg_period),
        .cfg_length (cfg_length),
        .cnt        (cnt),
        .len_shadow (len_shadow),
        .tc_c       (tc_c)
    );

    // Gate FSM with first output register stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            gate_s  <= 1'b0;
            start_s <= 1'b0;
            end_s   <= 1'b0;
            busy_s  <= 1'b0;
            phase_s <= '0;
        end else begin
            if (!mode_ok_c) begin
                state <= IDLE;
            end else begin
                unique case (state)
                    IDLE:    state <= (cfg_mode == MODE_CONT) ? RUN : ARMED;
                    ARMED:   if (run_next_c) state <= RUN;
                    RUN:     if (!run_next_c) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
            gate_s  <= active_c && (cnt < len_shadow);
            start_s <= active_c && (cnt == '0) && (len_shadow != '0);
            end_s   <= active_c && tc_c;
            busy_s  <= active_c;
            phase_s <= active_c ? cnt : '0;
        end
    end

    // Optional second output stage.
    if (PIPE != 0) begin : g_pipe
        logic             gate_q;
        logic             start_q;
        logic             end_q;
        logic             busy_q;
        logic [CNT_W-1:0] phase_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                gate_q  <= 1'b0;
                start_q <= 1'b0;
                end_q   <= 1'b0;
                busy_q  <= 1'b0;
                phase_q <= '0;
            end else begin
                gate_q  <= gate_s;
                start_q <= start_s;
                end_q   <= end_s;
                busy_q  <= busy_s;
                phase_q <= phase_s;
            end
        end

        assign gate       = gate_q;
        assign gate_start = start_q;
        assign period_end = end_q;
        assign busy       = busy_q;
        assign phase      = phase_q;
    end else begin : g_nopipe
        assign gate       = gate_s;
        assign gate_start = start_s;
        assign period_end = end_s;
        assign busy       = busy_s;
        assign phase      = phase_s;
    end

`ifdef DESER400_GATE_CNT_EN
    // Window counter; cleared when an off mode forces a return to IDLE, wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gate_count <= '0;
        end else if (!mode_ok_c && (state != IDLE)) begin
            gate_count <= '0;
        end else if (gate_start) begin
            gate_count <= gate_count + 16'(1);
        end
    end
`endif

endmodule
